// File: rtl/apb_fifo_ctrl.sv
// APB master arbitrating config, push and pop requests onto a Sync_FIFO slave.
// Optional `APB_TIMEOUT_EN aborts an ACCESS phase stalled for TIMEOUT_CYCLES.
module apb_fifo_ctrl #(
  parameter int unsigned WIDTH          = 8,
  parameter logic [31:0] REG_ADDR       = 32'h0000_0000,
  parameter logic [31:0] FIFO_ADDR      = 32'h8000_0000,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic             PCLK,
  input  logic             PRESETn,
  input  logic             cfg_req,
  input  logic [7:0]       cfg_data,
  output logic             cfg_ack,
  input  logic             wr_req,
  input  logic [WIDTH-1:0] wr_data,
  output logic             wr_ack,
  input  logic             rd_req,
  output logic             rd_ack,
  output logic [WIDTH-1:0] rd_data,
  output logic             err,
  output logic             busy,
  input  logic             full,
  input  logic             empty,
  output logic [31:0]      PADDR,
  output logic [2:0]       PPROT,
  output logic             PSEL,
  output logic             PENABLE,
  output logic             PWRITE,
  output logic [31:0]      PWDATA,
  output logic [3:0]       PSTRB,
  input  logic             PREADY,
  input  logic [31:0]      PRDATA,
  input  logic             PSLVERR
);

  localparam int unsigned NB = (WIDTH + 7) / 8;
  localparam logic [3:0] WR_STRB = 4'((5'd1 << NB) - 5'd1);

  typedef enum logic [1:0] {S_IDLE, S_SETUP, S_ACCESS} state_e;
  typedef enum logic [1:0] {G_CFG, G_WR, G_RD} gnt_e;

  state_e          state_q;
  gnt_e            gnt_q;
  logic            rr_rd_q;
  logic            psel_q;
  logic            penable_q;
  logic            pwrite_q;
  logic [31:0]     paddr_q;
  logic [31:0]     pwdata_q;
  logic [3:0]      pstrb_q;
  logic            cfg_ack_q;
  logic            wr_ack_q;
  logic            rd_ack_q;
  logic            err_q;
  logic            busy_q;
  logic [WIDTH-1:0] rd_data_q;

  logic wr_ok;
  logic rd_ok;
  logic g_cfg;
  logic g_wr;
  logic g_rd;
  logic tmo;
  logic done;

  assign wr_ok = wr_req & ~full;
  assign rd_ok = rd_req & ~empty;

  // rr_rd_q set means rd was granted last, so wr wins a tie
  assign g_cfg = cfg_req;
  assign g_wr  = ~cfg_req & wr_ok & (~rd_ok | rr_rd_q);
  assign g_rd  = ~cfg_req & rd_ok & (~wr_ok | ~rr_rd_q);

  assign done = (state_q == S_ACCESS) & (PREADY | tmo);

`ifdef APB_TIMEOUT_EN
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

  logic [TW-1:0] tcnt_q;

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      tcnt_q <= '0;
    end else if (state_q == S_SETUP) begin
      tcnt_q <= '0;
    end else if (state_q == S_ACCESS && !PREADY) begin
      tcnt_q <= tcnt_q + 1'b1;
    end
  end

  assign tmo = (state_q == S_ACCESS) & ~PREADY &
               (tcnt_q == TW'(TIMEOUT_CYCLES - 1));
`else
  logic unused_tmo;
  assign tmo        = 1'b0;
  assign unused_tmo = (TIMEOUT_CYCLES == 0);
`endif

  logic unused_prdata;
  assign unused_prdata = ^PRDATA;

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_q   <= S_IDLE;
      gnt_q     <= G_CFG;
      rr_rd_q   <= 1'b1;
      psel_q    <= 1'b0;
      penable_q <= 1'b0;
      pwrite_q  <= 1'b0;
      paddr_q   <= '0;
      pwdata_q  <= '0;
      pstrb_q   <= '0;
      cfg_ack_q <= 1'b0;
      wr_ack_q  <= 1'b0;
      rd_ack_q  <= 1'b0;
      err_q     <= 1'b0;
      busy_q    <= 1'b0;
      rd_data_q <= '0;
    end else begin
      cfg_ack_q <= 1'b0;
      wr_ack_q  <= 1'b0;
      rd_ack_q  <= 1'b0;
      err_q     <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (g_cfg | g_wr | g_rd) begin
            state_q <= S_SETUP;
            psel_q  <= 1'b1;
            busy_q  <= 1'b1;
            unique case (1'b1)
              g_cfg: begin
                gnt_q    <= G_CFG;
                paddr_q  <= REG_ADDR;
                pwrite_q <= 1'b1;
                pwdata_q <= {24'b0, cfg_data};
                pstrb_q  <= 4'b0001;
              end
              g_wr: begin
                gnt_q    <= G_WR;
                rr_rd_q  <= 1'b0;
                paddr_q  <= FIFO_ADDR;
                pwrite_q <= 1'b1;
                pwdata_q <= 32'(wr_data);
                pstrb_q  <= WR_STRB;
              end
              g_rd: begin
                gnt_q    <= G_RD;
                rr_rd_q  <= 1'b1;
                paddr_q  <= FIFO_ADDR;
                pwrite_q <= 1'b0;
                pstrb_q  <= 4'b0000;
              end
              default: ;
            endcase
          end
        end
        S_SETUP: begin
          state_q   <= S_ACCESS;
          penable_q <= 1'b1;
        end
        S_ACCESS: begin
          if (done) begin
            state_q   <= S_IDLE;
            psel_q    <= 1'b0;
            penable_q <= 1'b0;
            busy_q    <= 1'b0;
            cfg_ack_q <= (gnt_q == G_CFG);
            wr_ack_q  <= (gnt_q == G_WR);
            rd_ack_q  <= (gnt_q == G_RD);
            err_q     <= PREADY ? PSLVERR : 1'b1;
            if (PREADY && gnt_q == G_RD) begin
              rd_data_q <= PRDATA[WIDTH-1:0];
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign PPROT   = 3'b010;
  assign PSEL    = psel_q;
  assign PENABLE = penable_q;
  assign PWRITE  = pwrite_q;
  assign PADDR   = paddr_q;
  assign PWDATA  = pwdata_q;
  assign PSTRB   = pstrb_q;
  assign cfg_ack = cfg_ack_q;
  assign wr_ack  = wr_ack_q;
  assign rd_ack  = rd_ack_q;
  assign err     = err_q;
  assign busy    = busy_q;
  assign rd_data = rd_data_q;

endmodule

// File: tb/tb_apb_fifo_ctrl.sv
// Bench for apb_fifo_ctrl: per-cycle vector table plus sequences
// against a small 8-deep FIFO slave model.
module tb_apb_fifo_ctrl;

  localparam logic [31:0] FA = 32'h8000_0000;

  logic        PCLK = 1'b0;
  logic        PRESETn = 1'b0;
  logic        cfg_req = 1'b0;
  logic [7:0]  cfg_data = '0;
  logic        cfg_ack;
  logic        wr_req = 1'b0;
  logic [7:0]  wr_data = '0;
  logic        wr_ack;
  logic        rd_req = 1'b0;
  logic        rd_ack;
  logic [7:0]  rd_data;
  logic        err;
  logic        busy;
  logic        full;
  logic        empty;
  logic [31:0] PADDR;
  logic [2:0]  PPROT;
  logic        PSEL;
  logic        PENABLE;
  logic        PWRITE;
  logic [31:0] PWDATA;
  logic [3:0]  PSTRB;
  logic        PREADY;
  logic [31:0] PRDATA;
  logic        PSLVERR;

  logic       use_model = 1'b0;
  logic       t_full = 1'b0;
  logic       t_empty = 1'b1;
  logic       t_pready = 1'b0;
  logic       t_serr = 1'b0;
  logic [7:0] t_prd = '0;

  logic [7:0] mem [8];
  logic [2:0] wp = '0;
  logic [2:0] rp = '0;
  logic [3:0] cnt = '0;

  int checks = 0;
  int errors = 0;
  logic [7:0] sb [$];

  always #5 PCLK = ~PCLK;

  apb_fifo_ctrl dut (
    .PCLK(PCLK), .PRESETn(PRESETn),
    .cfg_req(cfg_req), .cfg_data(cfg_data), .cfg_ack(cfg_ack),
    .wr_req(wr_req), .wr_data(wr_data), .wr_ack(wr_ack),
    .rd_req(rd_req), .rd_ack(rd_ack), .rd_data(rd_data),
    .err(err), .busy(busy), .full(full), .empty(empty),
    .PADDR(PADDR), .PPROT(PPROT), .PSEL(PSEL), .PENABLE(PENABLE),
    .PWRITE(PWRITE), .PWDATA(PWDATA), .PSTRB(PSTRB),
    .PREADY(PREADY), .PRDATA(PRDATA), .PSLVERR(PSLVERR)
  );

  // FIFO slave model, active only when use_model is set
  always @(posedge PCLK) begin
    if (use_model && PSEL && PENABLE && PADDR == FA) begin
      if (PWRITE) begin
        mem[wp] <= PWDATA[7:0];
        wp <= wp + 3'd1;
        cnt <= cnt + 4'd1;
      end else begin
        rp <= rp + 3'd1;
        cnt <= cnt - 4'd1;
      end
    end
  end

  assign full    = use_model ? (cnt == 4'd8) : t_full;
  assign empty   = use_model ? (cnt == 4'd0) : t_empty;
  assign PREADY  = use_model ? 1'b1 : t_pready;
  assign PSLVERR = use_model ? 1'b0 : t_serr;
  assign PRDATA  = use_model ? {24'b0, mem[rp]} : {24'b0, t_prd};

  typedef struct {
    logic [6:0]  in;
    logic [7:0]  prd;
    logic [2:0]  ctl;
    logic [2:0]  ack;
    logic        err;
    logic [31:0] paddr;
    logic [31:0] pwdata;
    logic [3:0]  pstrb;
    logic [7:0]  rdd;
  } vec_t;

  vec_t tbl [22];

  function automatic vec_t mk(input logic [6:0] in, input logic [7:0] prd,
                              input logic [2:0] ctl, input logic [2:0] ack,
                              input logic e, input logic [31:0] pa,
                              input logic [31:0] pw, input logic [3:0] ps,
                              input logic [7:0] rdd);
    vec_t v;
    v.in = in; v.prd = prd; v.ctl = ctl; v.ack = ack; v.err = e;
    v.paddr = pa; v.pwdata = pw; v.pstrb = ps; v.rdd = rdd;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic sb_pop(input string nm);
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s: got pop %h, expected no data", nm, rd_data);
    end else begin
      chk(nm, rd_data, sb.pop_front());
    end
  endtask

  // k: 0 cfg, 1 wr, 2 rd
  task automatic xfer(input int k, input logic [7:0] d, output int lat);
    int psc;
    logic got;
    psc = 0;
    got = 1'b0;
    lat = 0;
    case (k)
      0: begin cfg_data = d; cfg_req = 1'b1; end
      1: begin wr_data = d; wr_req = 1'b1; end
      default: rd_req = 1'b1;
    endcase
    for (int n = 1; n <= 40 && !got; n++) begin
      @(negedge PCLK);
      if (PSEL) psc++;
      if (PSEL && !PENABLE) begin
        chk("setup paddr", PADDR, (k == 0) ? 32'h0 : FA);
        chk("setup pwrite", PWRITE, (k != 2));
        chk("setup pstrb", PSTRB, (k == 2) ? 4'h0 : 4'h1);
        if (k != 2) chk("setup pwdata", PWDATA, {24'b0, d});
      end
      if ((k == 0 && cfg_ack) || (k == 1 && wr_ack) ||
          (k == 2 && rd_ack)) begin
        got = 1'b1;
        lat = n;
      end
    end
    cfg_req = 1'b0;
    wr_req = 1'b0;
    rd_req = 1'b0;
    if (!got) begin
      checks++;
      errors++;
      $display("FAIL xfer timeout: got no ack, expected ack kind %0d", k);
    end else begin
      chk("psel cycles", psc, 2);
      chk("xfer err", err, 1'b0);
      if (k == 1) sb.push_back(d);
      if (k == 2) sb_pop("pop data");
    end
  endtask

  initial begin
    int lat;
    int psc;
    int n;
    int nacks;
    int ord [4];
    int cyc [4];
    logic got;
    logic [2:0] anyack;

    tbl[0]  = mk(7'b1000100, 8'h00, 3'b101, 3'b000, 0, 32'h0, 32'h3,  4'h1, 8'h00);
    tbl[1]  = mk(7'b1000100, 8'h00, 3'b111, 3'b000, 0, 32'h0, 32'h3,  4'h1, 8'h00);
    tbl[2]  = mk(7'b1000100, 8'h00, 3'b111, 3'b000, 0, 32'h0, 32'h3,  4'h1, 8'h00);
    tbl[3]  = mk(7'b1000100, 8'h00, 3'b111, 3'b000, 0, 32'h0, 32'h3,  4'h1, 8'h00);
    tbl[4]  = mk(7'b1000100, 8'h00, 3'b111, 3'b000, 0, 32'h0, 32'h3,  4'h1, 8'h00);
    tbl[5]  = mk(7'b1000011, 8'h00, 3'b000, 3'b100, 1, 32'h0, 32'h3,  4'h1, 8'h00);
    tbl[6]  = mk(7'b0110010, 8'h00, 3'b101, 3'b000, 0, FA,    32'h5A, 4'h1, 8'h00);
    tbl[7]  = mk(7'b0110010, 8'h00, 3'b111, 3'b000, 0, FA,    32'h5A, 4'h1, 8'h00);
    tbl[8]  = mk(7'b0110010, 8'h00, 3'b000, 3'b010, 0, FA,    32'h5A, 4'h1, 8'h00);
    tbl[9]  = mk(7'b0110010, 8'h00, 3'b100, 3'b000, 0, FA,    32'h5A, 4'h0, 8'h00);
    tbl[10] = mk(7'b0110010, 8'h00, 3'b110, 3'b000, 0, FA,    32'h5A, 4'h0, 8'h00);
    tbl[11] = mk(7'b0110010, 8'hC3, 3'b000, 3'b001, 0, FA,    32'h5A, 4'h0, 8'hC3);
    tbl[12] = mk(7'b0101010, 8'h00, 3'b000, 3'b000, 0, FA,    32'h5A, 4'h0, 8'hC3);
    tbl[13] = mk(7'b0101010, 8'h00, 3'b000, 3'b000, 0, FA,    32'h5A, 4'h0, 8'hC3);
    tbl[14] = mk(7'b0100010, 8'h00, 3'b101, 3'b000, 0, FA,    32'h5A, 4'h1, 8'hC3);
    tbl[15] = mk(7'b0100010, 8'h00, 3'b111, 3'b000, 0, FA,    32'h5A, 4'h1, 8'hC3);
    tbl[16] = mk(7'b0100011, 8'h77, 3'b000, 3'b010, 1, FA,    32'h5A, 4'h1, 8'hC3);
    tbl[17] = mk(7'b0010110, 8'h00, 3'b000, 3'b000, 0, FA,    32'h5A, 4'h1, 8'hC3);
    tbl[18] = mk(7'b0010011, 8'h3C, 3'b100, 3'b000, 0, FA,    32'h5A, 4'h0, 8'hC3);
    tbl[19] = mk(7'b0010011, 8'h3C, 3'b110, 3'b000, 0, FA,    32'h5A, 4'h0, 8'hC3);
    tbl[20] = mk(7'b0010011, 8'h3C, 3'b000, 3'b001, 1, FA,    32'h5A, 4'h0, 8'h3C);
    tbl[21] = mk(7'b0000010, 8'h00, 3'b000, 3'b000, 0, FA,    32'h5A, 4'h0, 8'h3C);

    // reset state
    @(negedge PCLK);
    chk("rst psel", PSEL, 1'b0);
    chk("rst penable", PENABLE, 1'b0);
    chk("rst pprot", PPROT, 3'b010);
    chk("rst busy", busy, 1'b0);
    chk("rst paddr", PADDR, 32'h0);
    chk("rst acks", {cfg_ack, wr_ack, rd_ack, err}, 4'b0);
    PRESETn = 1'b1;

    // reset asserted in the middle of ACCESS
    cfg_data = 8'h03;
    cfg_req = 1'b1;
    @(negedge PCLK);
    @(negedge PCLK);
    chk("pre-abort access", {PSEL, PENABLE}, 2'b11);
    #2 PRESETn = 1'b0;
    #1;
    chk("abort psel/penable", {PSEL, PENABLE}, 2'b00);
    @(negedge PCLK);
    cfg_req = 1'b0;
    @(negedge PCLK);
    PRESETn = 1'b1;
    anyack = '0;
    repeat (4) begin
      @(negedge PCLK);
      anyack = anyack | {cfg_ack, wr_ack, rd_ack};
    end
    chk("no ack after abort", anyack, 3'b000);
    chk("pprot after abort", PPROT, 3'b010);
    chk("idle after abort", PSEL, 1'b0);

    // per-cycle vector table
    cfg_data = 8'h03;
    wr_data = 8'h5A;
    for (int i = 0; i < 22; i++) begin
      {cfg_req, wr_req, rd_req, t_full, t_empty, t_pready, t_serr} = tbl[i].in;
      t_prd = tbl[i].prd;
      @(negedge PCLK);
      chk($sformatf("v%0d psel", i), PSEL, tbl[i].ctl[2]);
      chk($sformatf("v%0d penable", i), PENABLE, tbl[i].ctl[1]);
      chk($sformatf("v%0d busy", i), busy, tbl[i].ctl[2]);
      chk($sformatf("v%0d acks", i), {cfg_ack, wr_ack, rd_ack}, tbl[i].ack);
      chk($sformatf("v%0d err", i), err, tbl[i].err);
      chk($sformatf("v%0d paddr", i), PADDR, tbl[i].paddr);
      chk($sformatf("v%0d pwdata", i), PWDATA, tbl[i].pwdata);
      chk($sformatf("v%0d rd_data", i), rd_data, tbl[i].rdd);
      if (tbl[i].ctl[2]) begin
        chk($sformatf("v%0d pwrite", i), PWRITE, tbl[i].ctl[0]);
        chk($sformatf("v%0d pstrb", i), PSTRB, tbl[i].pstrb);
      end
    end
    {cfg_req, wr_req, rd_req} = 3'b000;
    t_pready = 1'b0;
    t_serr = 1'b0;

    // config then fill the FIFO
    use_model = 1'b1;
    @(negedge PCLK);
    xfer(0, 8'h01, lat);
    chk("cfg latency", lat, 3);
    for (int i = 0; i < 8; i++) begin
      xfer(1, 8'h10 + 8'(i), lat);
      chk($sformatf("wr%0d latency", i), lat, 3);
    end
    chk("full after 8", full, 1'b1);

    // wr blocked while full, released by a pop
    wr_data = 8'h99;
    wr_req = 1'b1;
    psc = 0;
    repeat (20) begin
      @(negedge PCLK);
      if (PSEL) psc++;
    end
    chk("no psel while full", psc, 0);
    rd_req = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 10 && !got; i++) begin
      @(negedge PCLK);
      if (rd_ack) got = 1'b1;
    end
    rd_req = 1'b0;
    chk("pop while full acked", got, 1'b1);
    sb_pop("pop while full");
    got = 1'b0;
    n = 0;
    for (int i = 1; i <= 10 && !got; i++) begin
      @(negedge PCLK);
      if (wr_ack) begin got = 1'b1; n = i; end
    end
    wr_req = 1'b0;
    chk("held wr latency", n, 3);
    if (got) sb.push_back(8'h99);

    // half full, then wr and rd held together
    for (int i = 0; i < 4; i++) xfer(2, 8'h00, lat);
    wr_data = 8'hA0;
    wr_req = 1'b1;
    rd_req = 1'b1;
    nacks = 0;
    for (int i = 1; i <= 30 && nacks < 4; i++) begin
      @(negedge PCLK);
      if (wr_ack) begin
        ord[nacks] = 1;
        cyc[nacks] = i;
        nacks++;
        sb.push_back(wr_data);
        wr_data = wr_data + 8'd1;
      end
      if (rd_ack) begin
        ord[nacks] = 2;
        cyc[nacks] = i;
        nacks++;
        sb_pop("alt pop");
      end
    end
    wr_req = 1'b0;
    rd_req = 1'b0;
    chk("alt ack count", nacks, 4);
    if (nacks == 4) begin
      chk("alt order", {ord[0][1:0], ord[1][1:0], ord[2][1:0], ord[3][1:0]},
          8'b01_10_01_10);
      chk("alt first", cyc[0], 3);
      for (int i = 1; i < 4; i++)
        chk($sformatf("alt spacing %0d", i), cyc[i] - cyc[i-1], 3);
    end

    // drain, then pop on empty
    for (int i = 0; i < 4; i++) xfer(2, 8'h00, lat);
    chk("empty after drain", empty, 1'b1);
    chk("scoreboard drained", sb.size(), 0);
    rd_req = 1'b1;
    psc = 0;
    repeat (20) begin
      @(negedge PCLK);
      if (PSEL) psc++;
    end
    rd_req = 1'b0;
    chk("no psel while empty", psc, 0);

`ifdef APB_TIMEOUT_EN
    use_model = 1'b0;
    t_pready = 1'b0;
    cfg_data = 8'h02;
    cfg_req = 1'b1;
    n = 0;
    got = 1'b0;
    for (int i = 1; i <= 40 && !got; i++) begin
      @(negedge PCLK);
      if (cfg_ack) begin got = 1'b1; n = i; end
    end
    chk("timeout err", got ? err : 1'b0, 1'b1);
    cfg_req = 1'b0;
    chk("timeout latency", n, 18);
    chk("timeout psel", PSEL, 1'b0);
`endif

    @(negedge PCLK);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
